// File: rtl/sort_result_streamer.sv
// Streams the first TOP_K entries of a sorter's ascending result as a valid/ready beat
// sequence, then pulses sorter_clear and waits for the sorter's valid to drop.
module sort_result_streamer #(
  parameter int WIDTH     = 32,
  parameter int NUM_NODES = 16,
  parameter int TOP_K     = NUM_NODES
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_vld,
  input  logic [NUM_NODES*WIDTH-1:0]           in_data,
  input  logic [NUM_NODES*$clog2(NUM_NODES)-1:0] in_idx,
  input  logic                                 abort,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [WIDTH-1:0]                     m_data,
  output logic [$clog2(NUM_NODES)-1:0]         m_idx,
  output logic [$clog2(NUM_NODES)-1:0]         m_rank,
  output logic                                 m_last,
  output logic                                 sorter_clear,
  output logic [15:0]                          frame_cnt
);

  localparam int IW = $clog2(NUM_NODES);
  localparam logic [IW-1:0] LAST_RANK = IW'(TOP_K - 1);

  typedef enum logic [1:0] {IDLE, STREAM, CLEAR, DRAIN} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_rank;
  logic              r_m_valid;
  logic [WIDTH-1:0]  r_m_data;
  logic [IW-1:0]     r_m_idx;
  logic              r_m_last;
  logic              r_sorter_clear;
  logic [15:0]       r_frame_cnt;

  logic [WIDTH-1:0]  r_buf_data [NUM_NODES];
  logic [IW-1:0]     r_buf_idx  [NUM_NODES];

  logic              w_capture;
  logic [IW-1:0]     w_next_rank;

  assign w_capture   = (r_state == IDLE) && in_vld;
  assign w_next_rank = r_rank + 1'b1;

  // Only the first TOP_K entries are ever streamed; the rest of the buffer stays zero.
  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_buf
    if (gi < TOP_K) begin : g_used
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_buf_data[gi] <= '0;
          r_buf_idx[gi]  <= '0;
        end else if (w_capture) begin
          r_buf_data[gi] <= in_data[gi*WIDTH +: WIDTH];
          r_buf_idx[gi]  <= in_idx[gi*IW +: IW];
        end
      end
    end else begin : g_unused
      assign r_buf_data[gi] = '0;
      assign r_buf_idx[gi]  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rank         <= '0;
      r_m_valid      <= 1'b0;
      r_m_data       <= '0;
      r_m_idx        <= '0;
      r_m_last       <= 1'b0;
      r_sorter_clear <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_sorter_clear <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_vld) begin
            r_state   <= STREAM;
            r_rank    <= '0;
            r_m_valid <= 1'b1;
            r_m_data  <= in_data[0 +: WIDTH];
            r_m_idx   <= in_idx[0 +: IW];
            r_m_last  <= (LAST_RANK == '0);
          end
        end
        STREAM: begin
          // Abort wins over a simultaneous final handshake and does not count the frame.
          if (abort || (m_ready && (r_rank == LAST_RANK))) begin
            r_state        <= CLEAR;
            r_rank         <= '0;
            r_m_valid      <= 1'b0;
            r_m_data       <= '0;
            r_m_idx        <= '0;
            r_m_last       <= 1'b0;
            r_sorter_clear <= 1'b1;
            if (!abort) begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end
          end else if (m_ready) begin
            r_rank   <= w_next_rank;
            r_m_data <= r_buf_data[w_next_rank];
            r_m_idx  <= r_buf_idx[w_next_rank];
            r_m_last <= (w_next_rank == LAST_RANK);
          end
        end
        CLEAR: begin
          r_state <= DRAIN;
        end
        DRAIN: begin
          // A result still flagged valid belongs to the frame just finished.
          if (!in_vld) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign m_idx        = r_m_idx;
  assign m_rank       = r_rank;
  assign m_last       = r_m_last;
  assign sorter_clear = r_sorter_clear;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_sort_result_streamer.sv
// Bench for sort_result_streamer: three instances (TOP_K = 4, 2, 1) with NUM_NODES=4, WIDTH=8.
module tb_sort_result_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_vld, abort, m_ready, m_valid, m_last, sorter_clear;
  logic [31:0] in_data;
  logic [7:0]  in_idx;
  logic [7:0]  m_data [3];
  logic [1:0]  m_idx [3];
  logic [1:0]  m_rank [3];
  logic [15:0] frame_cnt [3];
  logic [15:0] exp_fc [3];
  int          kk [3] = '{4, 2, 1};
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sort_result_streamer #(.WIDTH(8), .NUM_NODES(4), .TOP_K(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld[0]), .in_data(in_data), .in_idx(in_idx),
    .abort(abort[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
    .m_idx(m_idx[0]), .m_rank(m_rank[0]), .m_last(m_last[0]),
    .sorter_clear(sorter_clear[0]), .frame_cnt(frame_cnt[0]));

  sort_result_streamer #(.WIDTH(8), .NUM_NODES(4), .TOP_K(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld[1]), .in_data(in_data), .in_idx(in_idx),
    .abort(abort[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
    .m_idx(m_idx[1]), .m_rank(m_rank[1]), .m_last(m_last[1]),
    .sorter_clear(sorter_clear[1]), .frame_cnt(frame_cnt[1]));

  sort_result_streamer #(.WIDTH(8), .NUM_NODES(4), .TOP_K(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld[2]), .in_data(in_data), .in_idx(in_idx),
    .abort(abort[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]),
    .m_idx(m_idx[2]), .m_rank(m_rank[2]), .m_last(m_last[2]),
    .sorter_clear(sorter_clear[2]), .frame_cnt(frame_cnt[2]));

  typedef struct {
    string       name;
    int          d;
    logic [31:0] data;
    logic [7:0]  idx;
    int          mode;      // 0: always ready, 1: ready 1,0,0 repeating, 2: random
    int          abort_at;  // rank at which abort is raised, -1 for none
    bit          hold;      // keep in_vld high through the frame and after clear
    logic [31:0] exp_data;
    logic [7:0]  exp_idx;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_idle_outputs(input int d, input string name);
    chk({name, "/valid"}, 32'(m_valid[d]), 0);
    chk({name, "/last"},  32'(m_last[d]), 0);
    chk({name, "/data"},  32'(m_data[d]), 0);
    chk({name, "/idx"},   32'(m_idx[d]), 0);
    chk({name, "/rank"},  32'(m_rank[d]), 0);
  endtask

  task automatic run_frame(input int d, input logic [31:0] data, input logic [7:0] idx,
                           input logic [31:0] exp_data, input logic [7:0] exp_idx,
                           input int mode, input int abort_at, input bit hold,
                           input string name);
    int  beat = 0;
    int  cyc = 0;
    bit  done = 0;
    bit  aborted = 0;
    bit  r;
    in_data   = data;
    in_idx    = idx;
    in_vld[d] = 1'b1;
    step();
    // Buffer must be immune to new sorter data once streaming.
    in_vld[d] = hold;
    in_data   = $urandom;
    in_idx    = 8'($urandom);
    while (!done && cyc < 60) begin
      chk({name, "/valid"}, 32'(m_valid[d]), 1);
      chk({name, "/data"},  32'(m_data[d]), 32'(exp_data[beat*8 +: 8]));
      chk({name, "/idx"},   32'(m_idx[d]), 32'(exp_idx[beat*2 +: 2]));
      chk({name, "/rank"},  32'(m_rank[d]), 32'(beat));
      chk({name, "/last"},  32'(m_last[d]), 32'(beat == kk[d] - 1));
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_ready[d] = r;
      if (beat == abort_at) begin
        abort[d] = 1'b1;
        aborted  = 1'b1;
        done     = 1'b1;
      end else if (r && beat == kk[d] - 1) begin
        done = 1'b1;
      end
      step();
      abort[d]   = 1'b0;
      m_ready[d] = 1'b0;
      if (r && !done) beat++;
      cyc++;
    end
    chk({name, "/finished_in_budget"}, 32'(done), 1);
    if (!aborted) exp_fc[d]++;
    chk({name, "/clear_pulse"}, 32'(sorter_clear[d]), 1);
    chk({name, "/frame_cnt"}, 32'(frame_cnt[d]), 32'(exp_fc[d]));
    chk_idle_outputs(d, {name, "/after"});
    for (int i = 0; i < 3; i++) begin
      step();
      chk({name, "/clear_once"}, 32'(sorter_clear[d]), 0);
      chk({name, "/no_recapture"}, 32'(m_valid[d]), 0);
    end
    in_vld[d] = 1'b0;
    step();
    step();
  endtask

  initial begin
    vec_t        vt [6];
    logic [7:0]  a [4];
    logic [7:0]  t;
    logic [31:0] rdata;
    logic [7:0]  ridx;
    int          d;
    int          ab;

    vt[0] = '{"beats_k4", 0, 32'h0C09_0905, 8'b01_00_11_10, 0, -1, 1'b0, 32'h0C09_0905, 8'b01_00_11_10};
    vt[1] = '{"stall_k4", 0, 32'h0C09_0905, 8'b01_00_11_10, 1, -1, 1'b0, 32'h0C09_0905, 8'b01_00_11_10};
    vt[2] = '{"beats_k2", 1, 32'h0403_0201, 8'b00_01_10_11, 0, -1, 1'b0, 32'h0000_0201, 8'b0000_1011};
    vt[3] = '{"abort_r1", 0, 32'h0C09_0905, 8'b01_00_11_10, 0, 1,  1'b1, 32'h0000_0905, 8'b0000_1110};
    vt[4] = '{"beats_k1", 2, 32'h0605_0403, 8'b00_11_10_01, 0, -1, 1'b0, 32'h0000_0003, 8'b0000_0001};
    vt[5] = '{"stall_k2", 1, 32'hFF80_0100, 8'b10_01_00_11, 1, -1, 1'b1, 32'h0000_0100, 8'b0000_0011};

    rst_n = 1'b0; in_vld = '0; abort = '0; m_ready = '0; in_data = '0; in_idx = '0;
    exp_fc = '{default: 16'd0};
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk_idle_outputs(i, "reset");
      chk("reset/clear", 32'(sorter_clear[i]), 0);
      chk("reset/frame_cnt", 32'(frame_cnt[i]), 0);
    end
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i].d, vt[i].data, vt[i].idx, vt[i].exp_data, vt[i].exp_idx,
                vt[i].mode, vt[i].abort_at, vt[i].hold, vt[i].name);
      $display("vector %s dut=%0d frame_cnt=%0d", vt[i].name, vt[i].d, frame_cnt[vt[i].d]);
    end

    // Asynchronous reset in the middle of a frame at rank 2.
    in_data = 32'h2820_1810; in_idx = 8'b00_01_10_11; in_vld[0] = 1'b1;
    step();
    in_vld[0] = 1'b0; m_ready[0] = 1'b1;
    step();
    step();
    m_ready[0] = 1'b0;
    chk("pre_reset/rank", 32'(m_rank[0]), 2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs(0, "async_reset");
    chk("async_reset/clear", 32'(sorter_clear[0]), 0);
    chk("async_reset/frame_cnt", 32'(frame_cnt[0]), 0);
    exp_fc = '{default: 16'd0};
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset/clear", 32'(sorter_clear[0]), 0);
    run_frame(0, 32'h0C09_0905, 8'b01_00_11_10, 32'h0C09_0905, 8'b01_00_11_10, 0, -1, 1'b0, "post_reset");
    $display("sequence async_reset frame_cnt=%0d", frame_cnt[0]);

    // Frame counter wrap from 65535.
    force u0.r_frame_cnt = 16'hFFFF;
    #1 release u0.r_frame_cnt;
    exp_fc[0] = 16'hFFFF;
    chk("preload/frame_cnt", 32'(frame_cnt[0]), 32'hFFFF);
    run_frame(0, 32'h0C09_0905, 8'b01_00_11_10, 32'h0C09_0905, 8'b01_00_11_10, 0, -1, 1'b0, "wrap");
    $display("sequence wrap frame_cnt=%0d", frame_cnt[0]);

    // Random frames checked against the sorted-slice model.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) a[i] = 8'($urandom);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3 - i; j++)
          if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      rdata = {a[3], a[2], a[1], a[0]};
      ridx  = 8'($urandom);
      d     = $urandom_range(0, 2);
      ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, kk[d] - 1) : -1;
      run_frame(d, rdata, ridx, rdata, ridx, 2, ab, 1'($urandom_range(0, 1)), "random");
      $display("random frame %0d dut=%0d data=%h idx=%h abort_at=%0d frame_cnt=%0d",
               n, d, rdata, ridx, ab, frame_cnt[d]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
